multiexp_pnt_scl_feeder: RTL and testbench

Upstream feeder for the Fp2 multiexp core. Loads a batch of scalar/G2-point pairs once from the host stream into on-chip RAM. Then replays the whole batch KEY_BITS times as the looping 7-beat-per-pair stream that the core consumes, one pass per scalar bit. This lets the core walk the scalar bits MSB to LSB without the host re-sending data.

---
 rtl/multiexp_pnt_scl_feeder_pkg.sv | 16 +
 rtl/if_axi_stream.sv | 24 ++
 rtl/multiexp_pnt_scl_ram.sv | 23 ++
 rtl/multiexp_pnt_scl_feeder.sv | 203 ++++++++++++++++++++
 tb/tb_multiexp_pnt_scl_feeder.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/multiexp_pnt_scl_feeder_pkg.sv
// Shared multiexp feeder definitions: pair beat count and FSM encoding.
package multiexp_pnt_scl_feeder_pkg;

  localparam int BEATS_PER_FP2_PAIR = 7;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_REPLAY = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    LOAD   = ST_LOAD,
    REPLAY = ST_REPLAY
  } state_e;

endpackage

// File: rtl/if_axi_stream.sv
// Valid/ready beat stream with sop/eop framing and a ctl side channel.
interface if_axi_stream #(
  parameter int DAT_BITS = 381,
  parameter int CTL_BITS = 16
) ();

  logic                val;
  logic                rdy;
  logic                sop;
  logic                eop;
  logic [DAT_BITS-1:0] dat;
  logic [CTL_BITS-1:0] ctl;

  modport sink (
    input  val, sop, eop, dat, ctl,
    output rdy
  );

  modport source (
    output val, sop, eop, dat, ctl,
    input  rdy
  );

endinterface

// File: rtl/multiexp_pnt_scl_ram.sv
// Simple dual-port pair RAM, registered read (1-cycle latency).
module multiexp_pnt_scl_ram #(
  parameter int W     = 383,
  parameter int AW    = 13,
  parameter int DEPTH = 7168
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdat,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdat
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdat;
    if (i_re) o_rdat <= r_mem[i_raddr];
  end

endmodule

// File: rtl/multiexp_pnt_scl_feeder.sv
// Loads scalar/point pairs once, replays them KEY_BITS times to the core.
// Optional load framing check: MULTIEXP_FEEDER_FRAME_CHECK_EN.
module multiexp_pnt_scl_feeder
  import multiexp_pnt_scl_feeder_pkg::*;
#(
  parameter int DAT_BITS   = 381,
  parameter int CTL_BITS   = 16,
  parameter int KEY_BITS   = 256,
  parameter int MAX_NUM_IN = 1024,
  parameter int BEATS      = BEATS_PER_FP2_PAIR
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [63:0] i_num_in,
  if_axi_stream.sink   i_load_if,
  if_axi_stream.source o_pnt_scl_if,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  localparam int AW = $clog2(MAX_NUM_IN * BEATS);
  localparam int PW = $clog2(KEY_BITS) + 1;
  localparam int RW = DAT_BITS + 2;

  state_e              r_state;
  logic [AW-1:0]       r_last;
  logic [AW-1:0]       r_waddr;
  logic [AW-1:0]       r_raddr;
  logic [2:0]          r_beat;
  logic [PW-1:0]       r_pass;
  logic [CTL_BITS-1:0] r_ctl;
  logic                r_rd_done;
  logic                r_rvld;
  logic                r_done;
  logic                r_err;
  logic [1:0]          r_fcnt;
  logic [RW-1:0]       r_q0;
  logic [RW-1:0]       r_q1;

  logic          w_num_ok;
  logic [AW-1:0] w_n;
  logic [AW-1:0] w_last;
  logic          w_ld_acc;
  logic          w_ld_end;
  logic          w_frm_bad;
  logic [1:0]    w_tot;
  logic          w_oval;
  logic [RW-1:0] w_head;
  logic [RW-1:0] w_rdat;
  logic [RW-1:0] w_wdat;
  logic          w_pop;
  logic          w_pop_f;
  logic          w_push;
  logic [1:0]    w_widx;
  logic          w_rd_en;
  logic          w_final;

  assign w_num_ok = (i_num_in != 64'd0) &&
                    (i_num_in <= 64'(MAX_NUM_IN));
  assign w_n      = i_num_in[AW-1:0];
  assign w_last   = w_n * AW'(BEATS) - AW'(1);

  assign w_ld_acc = (r_state == LOAD) && i_load_if.val;
  assign w_ld_end = w_ld_acc && (r_waddr == r_last);
  assign w_wdat   = {r_beat == 3'd0,
                     r_beat == 3'(BEATS - 1),
                     i_load_if.dat};

`ifdef MULTIEXP_FEEDER_FRAME_CHECK_EN
  assign w_frm_bad = w_ld_acc &&
    ((i_load_if.sop && r_beat != 3'd0) ||
     (i_load_if.eop && r_beat != 3'(BEATS - 1)));
`else
  assign w_frm_bad = 1'b0;
`endif

  // Items in flight: skid entries plus the RAM output register.
  assign w_tot   = r_fcnt + {1'b0, r_rvld};
  assign w_oval  = (w_tot != 2'd0);
  assign w_head  = (r_fcnt != 2'd0) ? r_q0 : w_rdat;
  assign w_pop   = w_oval && o_pnt_scl_if.rdy;
  assign w_pop_f = w_pop && (r_fcnt != 2'd0);
  assign w_push  = r_rvld && !(w_pop && r_fcnt == 2'd0);
  assign w_widx  = r_fcnt - 2'(w_pop_f);
  assign w_rd_en = (r_state == REPLAY) && !r_rd_done &&
                   (w_tot < 2'd2);
  assign w_final = (r_state == REPLAY) && r_rd_done &&
                   (w_tot == 2'd1) && w_pop;

  multiexp_pnt_scl_ram #(
    .W     (RW),
    .AW    (AW),
    .DEPTH (MAX_NUM_IN * BEATS)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_ld_acc),
    .i_waddr (r_waddr),
    .i_wdat  (w_wdat),
    .i_re    (w_rd_en),
    .i_raddr (r_raddr),
    .o_rdat  (w_rdat)
  );

  assign i_load_if.rdy    = (r_state == LOAD);
  assign o_pnt_scl_if.val = w_oval;
  assign o_pnt_scl_if.dat = w_head[DAT_BITS-1:0];
  assign o_pnt_scl_if.sop = w_oval && w_head[DAT_BITS+1];
  assign o_pnt_scl_if.eop = w_oval && w_head[DAT_BITS];
  assign o_pnt_scl_if.ctl = r_ctl & ~CTL_BITS'(1);
  assign o_busy           = (r_state != IDLE);
  assign o_done           = r_done;
  assign o_err            = r_err;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_last    <= '0;
      r_waddr   <= '0;
      r_raddr   <= '0;
      r_beat    <= '0;
      r_pass    <= '0;
      r_ctl     <= '0;
      r_rd_done <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (i_start && w_num_ok) begin
            r_err   <= 1'b0;
            r_last  <= w_last;
            r_waddr <= '0;
            r_beat  <= '0;
            r_state <= LOAD;
          end else if (i_start) begin
            r_err <= 1'b1;
          end
        end
        LOAD: begin
          if (w_ld_acc) begin
            if (r_waddr == '0) r_ctl <= i_load_if.ctl;
            r_waddr <= r_waddr + AW'(1);
            r_beat  <= (r_beat == 3'(BEATS - 1)) ?
                       3'd0 : r_beat + 3'd1;
            if (w_frm_bad) begin
              r_err   <= 1'b1;
              r_state <= IDLE;
            end else if (w_ld_end) begin
              r_waddr   <= '0;
              r_beat    <= '0;
              r_raddr   <= '0;
              r_pass    <= '0;
              r_rd_done <= 1'b0;
              r_state   <= REPLAY;
            end
          end
        end
        REPLAY: begin
          if (w_rd_en) begin
            if (r_raddr == r_last) begin
              r_raddr <= '0;
              if (r_pass == PW'(KEY_BITS - 1))
                r_rd_done <= 1'b1;
              else
                r_pass <= r_pass + PW'(1);
            end else begin
              r_raddr <= r_raddr + AW'(1);
            end
          end
          if (w_final) begin
            r_done    <= 1'b1;
            r_pass    <= '0;
            r_rd_done <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fcnt <= '0;
      r_rvld <= 1'b0;
    end else begin
      r_rvld <= w_rd_en;
      r_fcnt <= r_fcnt - 2'(w_pop_f) + 2'(w_push);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_pop_f) r_q0 <= r_q1;
    if (w_push) begin
      if (w_widx == 2'd0) r_q0 <= w_rdat;
      else                r_q1 <= w_rdat;
    end
  end

endmodule

// File: tb/tb_multiexp_pnt_scl_feeder.sv
// Directed bench for multiexp_pnt_scl_feeder (KEY_BITS=4, MAX_NUM_IN=4).
module tb_multiexp_pnt_scl_feeder;

  localparam int DW = 32;
  localparam int CW = 16;
  localparam int KB = 4;
  localparam int MX = 4;
  localparam int NB = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] num;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int fails  = 0;
  int cyc;
  int nr;
  int vc;

  if_axi_stream #(.DAT_BITS(DW), .CTL_BITS(CW)) ld_if ();
  if_axi_stream #(.DAT_BITS(DW), .CTL_BITS(CW)) out_if ();

  always #5 clk = ~clk;

  multiexp_pnt_scl_feeder #(
    .DAT_BITS   (DW),
    .CTL_BITS   (CW),
    .KEY_BITS   (KB),
    .MAX_NUM_IN (MX),
    .BEATS      (NB)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_num_in     (num),
    .i_load_if    (ld_if),
    .o_pnt_scl_if (out_if),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err)
  );

  function automatic logic [31:0] exp_dat(input int tag, input int a);
    return (32'(tag) << 24) | 32'(a);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic [63:0] n);
    @(posedge clk); #1;
    start = 1'b1;
    num   = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Drives stop_k beats; beat bad_k additionally carries eop.
  task automatic do_load(input int tag, input int bad_k,
                         input int stop_k, output int not_rdy);
    not_rdy = 0;
    for (int k = 0; k < stop_k; k++) begin
      ld_if.val = 1'b1;
      ld_if.dat = exp_dat(tag, k);
      ld_if.sop = (k % NB == 0);
      ld_if.eop = (k % NB == NB - 1) || (k == bad_k);
      ld_if.ctl = (k == 0) ? 16'h00A5 : 16'h3C3C;
      if (ld_if.rdy !== 1'b1) not_rdy++;
      @(posedge clk); #1;
    end
    ld_if.val = 1'b0;
    ld_if.sop = 1'b0;
    ld_if.eop = 1'b0;
  endtask

  task automatic consume(input int tag, input int n, input bit rnd,
                         input int stop_at, output int c);
    int idx;
    int a;
    int dn;
    idx = 0;
    dn  = 0;
    c   = 0;
    while (idx < stop_at && c < 4000) begin
      out_if.rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (done === 1'b1) dn++;
      if (out_if.val === 1'b1 && out_if.rdy) begin
        a = idx % (n * NB);
        chk("beat",
            {14'd0, out_if.dat, out_if.sop, out_if.eop, out_if.ctl},
            {14'd0, exp_dat(tag, a), 1'(a % NB == 0),
             1'(a % NB == NB - 1), 16'h00A4});
        idx++;
      end
      @(posedge clk); #1;
      c++;
    end
    chk("beat_count", 64'(idx), 64'(stop_at));
    chk("early_done", 64'(dn), 64'd0);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    num        = '0;
    ld_if.val  = 1'b0;
    ld_if.sop  = 1'b0;
    ld_if.eop  = 1'b0;
    ld_if.dat  = '0;
    ld_if.ctl  = '0;
    out_if.rdy = 1'b0;

    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_ldrdy", 64'(ld_if.rdy), 64'd0);
    chk("rst_val", 64'(out_if.val), 64'd0);
    chk("rst_sop", 64'(out_if.sop), 64'd0);
    chk("rst_eop", 64'(out_if.eop), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    do_start(64'd0);
    chk("num0_err", 64'(err), 64'd1);
    chk("num0_busy", 64'(busy), 64'd0);
    chk("num0_ldrdy", 64'(ld_if.rdy), 64'd0);
    do_start(64'(MX + 1));
    chk("numbig_err", 64'(err), 64'd1);
    chk("numbig_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk("numbig_ldrdy", 64'(ld_if.rdy), 64'd0);

    do_start(64'd3);
    chk("a_err_clr", 64'(err), 64'd0);
    chk("a_busy", 64'(busy), 64'd1);
    do_load(1, -1, 3 * NB, nr);
    chk("a_load_rdy", 64'(nr), 64'd0);
    chk("a_lat1", 64'(out_if.val), 64'd0);
    @(posedge clk); #1;
    chk("a_lat2", 64'(out_if.val), 64'd1);
    consume(1, 3, 1'b0, 3 * NB * KB, cyc);
    chk("a_cycles", 64'(cyc), 64'(3 * NB * KB));
    chk("a_done", 64'(done), 64'd1);
    chk("a_busy_end", 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk("a_done_pulse", 64'(done), 64'd0);
    chk("a_val_idle", 64'(out_if.val), 64'd0);

    do_start(64'd3);
    do_load(1, -1, 3 * NB, nr);
    chk("b_load_rdy", 64'(nr), 64'd0);
    consume(1, 3, 1'b1, 3 * NB * KB, cyc);
    chk("b_done", 64'(done), 64'd1);

    do_start(64'd3);
    do_load(2, -1, 3 * NB, nr);
    consume(2, 3, 1'b0, 2 * 3 * NB + 5, cyc);
    #2 rst = 1'b1;
    #1;
    chk("c_rst_val", 64'(out_if.val), 64'd0);
    chk("c_rst_busy", 64'(busy), 64'd0);
    chk("c_rst_ldrdy", 64'(ld_if.rdy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    do_start(64'd2);
    do_load(3, -1, 2 * NB, nr);
    chk("c_load_rdy", 64'(nr), 64'd0);
    consume(3, 2, 1'b0, 2 * NB * KB, cyc);
    chk("c_done", 64'(done), 64'd1);

    do_start(64'(MX));
    do_load(4, -1, MX * NB, nr);
    chk("d_load_rdy", 64'(nr), 64'd0);
    @(posedge clk); #1;
    consume(4, MX, 1'b0, MX * NB * KB, cyc);
    chk("d_cycles", 64'(cyc), 64'(MX * NB * KB));
    chk("d_done", 64'(done), 64'd1);

`ifdef MULTIEXP_FEEDER_FRAME_CHECK_EN
    do_start(64'd3);
    do_load(5, NB + 3, NB + 4, nr);
    chk("e_load_rdy", 64'(nr), 64'd0);
    chk("e_err", 64'(err), 64'd1);
    chk("e_busy", 64'(busy), 64'd0);
    chk("e_ldrdy", 64'(ld_if.rdy), 64'd0);
    vc = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_if.val !== 1'b0) vc++;
      @(posedge clk); #1;
    end
    chk("e_no_val", 64'(vc), 64'd0);
`else
    do_start(64'd3);
    do_load(5, NB + 3, 3 * NB, nr);
    chk("e_load_rdy", 64'(nr), 64'd0);
    chk("e_err", 64'(err), 64'd0);
    consume(5, 3, 1'b0, 3 * NB * KB, cyc);
    chk("e_done", 64'(done), 64'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
